lane_scheduler: RTL

Sequences the lane-pattern generator for the jumping-frog playfield: on a programmable tick it steps the generator, captures the new 8-bit lane pattern, and shifts it into the top of an 8-row scrolling playfield buffer. It can insert an all-clear safe row between pattern rows. It sits between the pseudo-random lane generator and the LED-matrix driver and collision logic, which read `grid` directly.

---
 rtl/lane_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/lane_scheduler.sv
// Playfield scroll sequencer: on each programmable tick, steps the lane generator and shifts its
// pattern (or an all-clear safe row) into the top of a scrolling row buffer.
module lane_scheduler #(
  parameter int unsigned DIV_W = 24,
  parameter int unsigned ROWS  = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  gap_en,
  input  logic [DIV_W-1:0]      period,
  input  logic [WIDTH-1:0]      line_in,
  output logic                  gen_step,
  output logic [ROWS*WIDTH-1:0] grid,
  output logic                  scroll,
  output logic [15:0]           scroll_count,
  output logic                  busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StStep  = 2'd2;
  localparam logic [1:0] StShift = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  gap_en_q, gap_en_d;
  logic [ROWS*WIDTH-1:0] grid_q, grid_d;
  logic [15:0]           count_q, count_d;
  logic                  scroll_q, scroll_d;

  logic [DIV_W-1:0]      period_m1;
  logic                  gap_row;
  logic [WIDTH-1:0]      new_row;

  // A period of 0 behaves as 1, so the terminal count never underflows.
  assign period_m1 = (period == '0) ? '0 : period - DIV_W'(1);

  // gap_en_q holds the value sampled in STEP so the following SHIFT agrees with the strobe.
  assign gap_row = gap_en_q & phase_q;
  assign new_row = gap_row ? '0 : line_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    gap_en_d = gap_en_q;
    grid_d   = grid_q;
    count_d  = count_q;
    scroll_d = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
        StWait: begin
          if (!pause) begin
            if (cnt_q >= period_m1) begin
              state_d = StStep;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + DIV_W'(1);
            end
          end
        end
        StStep: begin
          gap_en_d = gap_en;
          state_d  = StShift;
        end
        StShift: begin
          grid_d   = {grid_q[(ROWS-1)*WIDTH-1:0], new_row};
          phase_d  = gap_en_q ? ~phase_q : 1'b0;
          count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          scroll_d = 1'b1;
          cnt_d    = '0;
          state_d  = StWait;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      gap_en_q <= 1'b0;
      grid_q   <= '0;
      count_q  <= '0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      gap_en_q <= gap_en_d;
      grid_q   <= grid_d;
      count_q  <= count_d;
      scroll_q <= scroll_d;
    end
  end

  // Gap rows leave the generator untouched.
  assign gen_step     = (state_q == StStep) && !(gap_en && phase_q);
  assign busy         = (state_q != StIdle);
  assign grid         = grid_q;
  assign scroll       = scroll_q;
  assign scroll_count = count_q;

endmodule
